// File: rtl/dma_cmd_pkg.sv
// Shared widths, command-type encodings and the held-command record for the
// DMA command arbiter slice.
package dma_cmd_pkg;

  localparam int DMA_TAG_W  = 6;
  localparam int DMA_DATA_W = 1024;
  localparam int DMA_BE_W   = 128;
  localparam int DMA_EA_W   = 64;

  localparam logic CMD_TYPE_WR = 1'b0;
  localparam logic CMD_TYPE_RD = 1'b1;

  typedef struct packed {
    logic                  cmd_type;
    logic [DMA_DATA_W-1:0] data;
    logic [DMA_BE_W-1:0]   be;
    logic [DMA_EA_W-1:0]   ea;
    logic [DMA_TAG_W-1:0]  tag;
  } dma_cmd_t;

endpackage

// File: rtl/dma_cmd_arbiter_if.sv
// Bundle of the write/read command channels, the merged command stream, the
// completion pulses and status. The arbiter uses master, its neighbours slave.
interface dma_cmd_arbiter_if #(
  parameter int CNTW = 6
);
  import dma_cmd_pkg::*;

  logic                  wr_cmd_valid;
  logic                  wr_cmd_ready;
  logic [DMA_DATA_W-1:0] wr_cmd_data;
  logic [DMA_BE_W-1:0]   wr_cmd_be;
  logic [DMA_EA_W-1:0]   wr_cmd_ea;
  logic [DMA_TAG_W-1:0]  wr_cmd_tag;

  logic                  rd_cmd_valid;
  logic                  rd_cmd_ready;
  logic [DMA_BE_W-1:0]   rd_cmd_be;
  logic [DMA_EA_W-1:0]   rd_cmd_ea;
  logic [DMA_TAG_W-1:0]  rd_cmd_tag;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_type;
  logic [DMA_DATA_W-1:0] cmd_data;
  logic [DMA_BE_W-1:0]   cmd_be;
  logic [DMA_EA_W-1:0]   cmd_ea;
  logic [DMA_TAG_W-1:0]  cmd_tag;

  logic                  wr_done;
  logic                  rd_done;
  logic [CNTW-1:0]       outstanding;
  logic                  idle;
  logic                  fir_credit_underflow;

  modport master (
    input  wr_cmd_valid, wr_cmd_data, wr_cmd_be, wr_cmd_ea, wr_cmd_tag,
    output wr_cmd_ready,
    input  rd_cmd_valid, rd_cmd_be, rd_cmd_ea, rd_cmd_tag,
    output rd_cmd_ready,
    output cmd_valid, cmd_type, cmd_data, cmd_be, cmd_ea, cmd_tag,
    input  cmd_ready,
    input  wr_done, rd_done,
    output outstanding, idle, fir_credit_underflow
  );

  modport slave (
    output wr_cmd_valid, wr_cmd_data, wr_cmd_be, wr_cmd_ea, wr_cmd_tag,
    input  wr_cmd_ready,
    output rd_cmd_valid, rd_cmd_be, rd_cmd_ea, rd_cmd_tag,
    input  rd_cmd_ready,
    input  cmd_valid, cmd_type, cmd_data, cmd_be, cmd_ea, cmd_tag,
    output cmd_ready,
    output wr_done, rd_done,
    input  outstanding, idle, fir_credit_underflow
  );

endinterface

// File: rtl/dma_credit_counter.sv
// In-flight command counter: one increment, two independent decrements,
// clamps at zero and latches a sticky underflow flag.
module dma_credit_counter #(
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  input  logic            dec_a_i,
  input  logic            dec_b_i,
  output logic [CNTW-1:0] count_o,
  output logic            underflow_o
);

  logic [CNTW-1:0] count_q, count_d;
  logic            underflow_q, underflow_d;
  logic [CNTW:0]   sum, dec, diff;

  // One spare bit so the net can be compared before it wraps below zero.
  always_comb begin
    sum         = {1'b0, count_q} + {{CNTW{1'b0}}, inc_i};
    dec         = {{CNTW{1'b0}}, dec_a_i} + {{CNTW{1'b0}}, dec_b_i};
    diff        = sum - dec;
    count_d     = diff[CNTW-1:0];
    underflow_d = underflow_q;
    if (dec > sum) begin
      count_d     = '0;
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign count_o     = count_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/dma_cmd_arbiter.sv
// Round-robin merge of write and read DMA commands into one registered
// command stream, throttled by an outstanding-command credit limit.
module dma_cmd_arbiter
  import dma_cmd_pkg::*;
#(
  parameter int CREDITS = 32,
  parameter int CNTW    = 6
) (
  input logic               clk_afu,
  input logic               rst,
  dma_cmd_arbiter_if.master bus
);

  logic            cmd_valid_q, cmd_valid_d;
  dma_cmd_t        cmd_q, cmd_d;
  logic            last_rd_q, last_rd_d;
  logic            can_load, grant_wr, grant_rd;
  logic            wr_accept, rd_accept, accept;
  logic [CNTW-1:0] outstanding;
  logic            underflow;

  // Credit check uses the registered count only; same-cycle dones help next cycle.
  always_comb begin
    can_load  = (!cmd_valid_q || bus.cmd_ready) && (outstanding < CNTW'(CREDITS));
    grant_wr  = bus.wr_cmd_valid && (!bus.rd_cmd_valid || last_rd_q);
    grant_rd  = bus.rd_cmd_valid && !grant_wr;
    wr_accept = can_load && grant_wr;
    rd_accept = can_load && grant_rd;
    accept    = wr_accept || rd_accept;
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    last_rd_d   = last_rd_q;
    if (cmd_valid_q && bus.cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
    if (wr_accept) begin
      cmd_valid_d = 1'b1;
      last_rd_d   = 1'b0;
      cmd_d       = '{cmd_type: CMD_TYPE_WR, data: bus.wr_cmd_data, be: bus.wr_cmd_be,
                      ea: bus.wr_cmd_ea, tag: bus.wr_cmd_tag};
    end else if (rd_accept) begin
      cmd_valid_d = 1'b1;
      last_rd_d   = 1'b1;
      cmd_d       = '{cmd_type: CMD_TYPE_RD, data: '0, be: bus.rd_cmd_be,
                      ea: bus.rd_cmd_ea, tag: bus.rd_cmd_tag};
    end
  end

  // last_rd resets high so a write wins the first tie.
  always_ff @(posedge clk_afu) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      last_rd_q   <= 1'b1;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      last_rd_q   <= last_rd_d;
    end
  end

  dma_credit_counter #(
    .CNTW(CNTW)
  ) u_credit (
    .clk         (clk_afu),
    .rst         (rst),
    .inc_i       (accept),
    .dec_a_i     (bus.wr_done),
    .dec_b_i     (bus.rd_done),
    .count_o     (outstanding),
    .underflow_o (underflow)
  );

  assign bus.wr_cmd_ready         = wr_accept;
  assign bus.rd_cmd_ready         = rd_accept;
  assign bus.cmd_valid            = cmd_valid_q;
  assign bus.cmd_type             = cmd_q.cmd_type;
  assign bus.cmd_data             = cmd_q.data;
  assign bus.cmd_be               = cmd_q.be;
  assign bus.cmd_ea               = cmd_q.ea;
  assign bus.cmd_tag              = cmd_q.tag;
  assign bus.outstanding          = outstanding;
  assign bus.idle                 = (outstanding == '0) && !cmd_valid_q;
  assign bus.fir_credit_underflow = underflow;

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// Randomized and directed bench for dma_cmd_arbiter against a transaction-level
// model: a held-command slot, an integer in-flight count and a round-robin flag.
module tb_dma_cmd_arbiter;
  import dma_cmd_pkg::*;

  localparam int CREDITS = 32;
  localparam int CNTW    = 6;

  logic clk_afu = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_afu = ~clk_afu;

  dma_cmd_arbiter_if #(.CNTW(CNTW)) bus ();

  dma_cmd_arbiter #(
    .CREDITS(CREDITS),
    .CNTW   (CNTW)
  ) dut (
    .clk_afu(clk_afu),
    .rst    (rst),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  bit       m_valid;
  dma_cmd_t m_cmd;
  int       m_out;
  bit       m_uf;
  bit       m_last_rd;

  task automatic check_eq(string tag, logic [255:0] got, logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DMA_DATA_W-1:0] rand_data();
    logic [DMA_DATA_W-1:0] v;
    for (int k = 0; k < DMA_DATA_W / 32; k++) v[k*32+:32] = $urandom;
    return v;
  endfunction

  function automatic logic [DMA_BE_W-1:0] rand_be();
    logic [DMA_BE_W-1:0] v;
    for (int k = 0; k < DMA_BE_W / 32; k++) v[k*32+:32] = $urandom;
    return v;
  endfunction

  task automatic rand_fields();
    bus.wr_cmd_data = rand_data();
    bus.wr_cmd_be   = rand_be();
    bus.wr_cmd_ea   = {$urandom, $urandom};
    bus.wr_cmd_tag  = DMA_TAG_W'($urandom);
    bus.rd_cmd_be   = rand_be();
    bus.rd_cmd_ea   = {$urandom, $urandom};
    bus.rd_cmd_tag  = DMA_TAG_W'($urandom);
  endtask

  task automatic clear_inputs();
    bus.wr_cmd_valid = 1'b0;
    bus.rd_cmd_valid = 1'b0;
    bus.cmd_ready    = 1'b0;
    bus.wr_done      = 1'b0;
    bus.rd_done      = 1'b0;
  endtask

  task automatic check_outputs(string ph);
    check_eq({ph, ".cmd_valid"}, 256'(bus.cmd_valid), 256'(m_valid));
    if (m_valid) begin
      check_eq({ph, ".cmd_type"}, 256'(bus.cmd_type), 256'(m_cmd.cmd_type));
      check_eq({ph, ".cmd_ea"}, 256'(bus.cmd_ea), 256'(m_cmd.ea));
      check_eq({ph, ".cmd_tag"}, 256'(bus.cmd_tag), 256'(m_cmd.tag));
      check_eq({ph, ".cmd_be"}, 256'(bus.cmd_be), 256'(m_cmd.be));
      for (int k = 0; k < 4; k++)
        check_eq({ph, ".cmd_data"}, bus.cmd_data[k*256+:256], m_cmd.data[k*256+:256]);
    end
    check_eq({ph, ".outstanding"}, 256'(bus.outstanding), 256'(m_out));
    check_eq({ph, ".underflow"}, 256'(bus.fir_credit_underflow), 256'(m_uf));
    check_eq({ph, ".idle"}, 256'(bus.idle), 256'((m_out == 0) && !m_valid));
  endtask

  // Caller sets inputs just after a rising edge; one clock is then consumed.
  task automatic step(string ph);
    bit can, gw, gr, acc;
    int net;
    #1;
    can = (!m_valid || bus.cmd_ready) && (m_out < CREDITS);
    gw  = bus.wr_cmd_valid && (!bus.rd_cmd_valid || m_last_rd);
    gr  = bus.rd_cmd_valid && !gw;
    check_eq({ph, ".wr_ready"}, 256'(bus.wr_cmd_ready), 256'(can && gw));
    check_eq({ph, ".rd_ready"}, 256'(bus.rd_cmd_ready), 256'(can && gr));
    acc = can && (gw || gr);
    if (acc) begin
      m_valid   = 1'b1;
      m_last_rd = gr;
      if (gw) m_cmd = '{cmd_type: CMD_TYPE_WR, data: bus.wr_cmd_data, be: bus.wr_cmd_be,
                        ea: bus.wr_cmd_ea, tag: bus.wr_cmd_tag};
      else    m_cmd = '{cmd_type: CMD_TYPE_RD, data: '0, be: bus.rd_cmd_be,
                        ea: bus.rd_cmd_ea, tag: bus.rd_cmd_tag};
      $display("[TB] %s accept %s tag=%0d ea=%h", ph, gw ? "WR" : "RD", m_cmd.tag, m_cmd.ea);
    end else if (m_valid && bus.cmd_ready) begin
      m_valid = 1'b0;
    end
    net = m_out + int'(acc) - int'(bus.wr_done) - int'(bus.rd_done);
    if (net < 0) begin
      m_out = 0;
      m_uf  = 1'b1;
    end else begin
      m_out = net;
    end
    @(posedge clk_afu);
    #1;
    check_outputs(ph);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk_afu);
    @(posedge clk_afu);
    #1;
    rst       = 1'b0;
    m_valid   = 1'b0;
    m_cmd     = '0;
    m_out     = 0;
    m_uf      = 1'b0;
    m_last_rd = 1'b1;
    check_outputs("reset");
    check_eq("reset.cmd_type", 256'(bus.cmd_type), 256'(0));
    check_eq("reset.cmd_ea", 256'(bus.cmd_ea), 256'(0));
    check_eq("reset.cmd_tag", 256'(bus.cmd_tag), 256'(0));
    check_eq("reset.cmd_be", 256'(bus.cmd_be), 256'(0));
    check_eq("reset.cmd_data", bus.cmd_data[255:0], 256'(0));
  endtask

  initial begin
    logic [DMA_EA_W-1:0]  held_ea;
    logic [DMA_TAG_W-1:0] held_tag;

    clear_inputs();
    rand_fields();
    do_reset();

    // First write after reset
    bus.wr_cmd_valid = 1'b1;
    bus.wr_cmd_ea    = 64'h1000;
    bus.wr_cmd_tag   = 6'd5;
    bus.cmd_ready    = 1'b1;
    step("first");
    check_eq("first.cmd_type", 256'(bus.cmd_type), 256'(CMD_TYPE_WR));
    check_eq("first.cmd_ea", 256'(bus.cmd_ea), 256'h1000);
    check_eq("first.cmd_tag", 256'(bus.cmd_tag), 256'd5);
    check_eq("first.outstanding", 256'(bus.outstanding), 256'd1);

    // Alternation from reset: W, R, W, R ...
    do_reset();
    bus.wr_cmd_valid = 1'b1;
    bus.rd_cmd_valid = 1'b1;
    bus.cmd_ready    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_fields();
      step("alt");
      check_eq("alt.order", 256'(bus.cmd_type), 256'(i % 2));
    end

    // Back-pressure: held command stays put, nothing accepted
    bus.cmd_ready = 1'b0;
    rand_fields();
    step("stall_load");
    held_ea  = bus.cmd_ea;
    held_tag = bus.cmd_tag;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      step("stall");
      check_eq("stall.ea_stable", 256'(bus.cmd_ea), 256'(held_ea));
      check_eq("stall.tag_stable", 256'(bus.cmd_tag), 256'(held_tag));
    end
    bus.cmd_ready = 1'b1;
    step("stall_release");

    // Credit exhaustion and return
    do_reset();
    bus.wr_cmd_valid = 1'b1;
    bus.cmd_ready    = 1'b1;
    for (int i = 0; i < 34; i++) begin
      rand_fields();
      step("fill");
    end
    check_eq("full.outstanding", 256'(bus.outstanding), 256'(CREDITS));
    bus.wr_done = 1'b1;
    step("full_done");
    check_eq("full_done.outstanding", 256'(bus.outstanding), 256'(CREDITS - 1));
    bus.wr_done = 1'b0;
    step("full_return");

    // Accept plus both dones at four in flight
    do_reset();
    bus.wr_cmd_valid = 1'b1;
    bus.cmd_ready    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      step("pre4");
    end
    bus.wr_done = 1'b1;
    bus.rd_done = 1'b1;
    step("net_minus1");
    check_eq("net_minus1.outstanding", 256'(bus.outstanding), 256'd3);
    clear_inputs();

    // Underflow is sticky until reset
    do_reset();
    bus.rd_done = 1'b1;
    step("uflow");
    check_eq("uflow.flag", 256'(bus.fir_credit_underflow), 256'd1);
    bus.rd_done = 1'b0;
    for (int i = 0; i < 3; i++) step("uflow_hold");
    do_reset();

    // Random traffic with occasional mid-operation reset
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      bus.wr_cmd_valid = 1'($urandom_range(0, 1));
      bus.rd_cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_ready    = ($urandom_range(0, 3) != 0);
      bus.wr_done      = ($urandom_range(0, 3) == 0);
      bus.rd_done      = ($urandom_range(0, 3) == 0);
      step("rand");
      if (i % 200 == 199) do_reset();
    end

    clear_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_cmd_arbiter.md
Name: dma_cmd_arbiter

Overview:
- Sits directly downstream of the data bridge write and read channels.
- Merges the dma_wr_cmd and dma_rd_cmd streams into one registered command stream toward the TLx command encoder.
- Round-robin arbitration between write and read.
- Throttles issue with an outstanding-command credit counter; credits return on command-completion pulses from the response decoder.

Parameters:
- CREDITS, 32, max commands in flight (accepted, not yet completed); legal range 1..63.
- CNTW, 6, width of the outstanding counter; must satisfy 2^CNTW > CREDITS.

Ports:
- clk_afu  in  1  single clock
- rst  in  1  synchronous, active-high reset
- wr_cmd_valid  in  1  write command valid (from data bridge)
- wr_cmd_ready  out  1  write command accepted this cycle when valid&ready
- wr_cmd_data  in  1024  write payload
- wr_cmd_be  in  128  write byte enables
- wr_cmd_ea  in  64  effective address
- wr_cmd_tag  in  6  write tag
- rd_cmd_valid  in  1  read command valid
- rd_cmd_ready  out  1  read command accept
- rd_cmd_be  in  128  read byte enables
- rd_cmd_ea  in  64  read address
- rd_cmd_tag  in  6  read tag
- cmd_valid  out  1  merged command valid
- cmd_ready  in  1  encoder accept
- cmd_type  out  1  0 = write, 1 = read
- cmd_data  out  1024  payload; zero for reads
- cmd_be  out  128  byte enables
- cmd_ea  out  64  address
- cmd_tag  out  6  tag
- wr_done  in  1  one write completed (credit return)
- rd_done  in  1  one read completed (credit return)
- outstanding  out  CNTW  current in-flight count
- idle  out  1  outstanding==0 and !cmd_valid
- fir_credit_underflow  out  1  sticky error

Behaviour:
- Reset values: cmd_valid=0, cmd_type=0, cmd_data/be/ea/tag=0, outstanding=0, fir_credit_underflow=0, last_grant=1 (read), so write wins the first tie.
- One output holding register (single stage, no skid).
- Register state:
  - empty = !cmd_valid
  - can_load = (!cmd_valid | cmd_ready) & (outstanding_next_avail < CREDITS)
  - outstanding_next_avail = outstanding, i.e. the current count excluding this cycle's done pulses (conservative).
- Grant is combinational from valids and last_grant:
  - only one side valid: that side wins.
  - both valid: the side != last_grant wins.
- wr_cmd_ready = can_load & grant_wr; rd_cmd_ready = can_load & grant_rd. Readies depend on cmd_ready (combinational path, accepted).
- On accept: load the output register next cycle with the winner's fields; cmd_data is forced to 0 on read. last_grant updates to the winner.
- Input-to-output latency is 1 cycle. Sustained throughput is 1 cmd/cycle while credits remain.
- With cmd_valid & !cmd_ready, the register holds and all fields stay stable (AXI-style; valid never drops without ready).
- Counter update each cycle: outstanding += accept - wr_done - rd_done.
  - Accept plus two dones in the same cycle gives a net of -1.
  - Width arithmetic is in CNTW+1 bits and saturates at 0.
- Underflow: decrement exceeding the current count (e.g. done while 0, or both dones while 1). The count clamps to 0 and fir_credit_underflow sets; it clears only on rst.
- Full: outstanding==CREDITS drops both readies. Ready reasserts the cycle after a done pulse lowers the count.
- Reset mid-operation: the held command is discarded, cmd_valid drops next cycle, and the counter clears. Upstream retry is the caller's job.

Decomposition:
- Shared package dma_cmd_pkg: CMD_TYPE_WR/CMD_TYPE_RD constants, DMA_TAG_W=6, DMA_DATA_W=1024, DMA_BE_W=128, DMA_EA_W=64.
- One natural sub-module: dma_credit_counter (up/down counter with dual decrement, saturation, underflow flag). The arbiter and holding register stay in the top.

Test Plan:
- Reset, then wr_cmd_valid with ea=0x1000, tag=5, cmd_ready=1 -> cmd_valid the next cycle with type=0, ea=0x1000, tag=5; outstanding=1.
- Both valid continuously, cmd_ready=1, dones idle, CREDITS=32 -> grants alternate W,R,W,R…, starting with W. Read entries show cmd_data=0.
- cmd_ready=0 for 5 cycles with a command held -> output fields constant; both readies 0; no accept is lost.
- Issue 32 commands without done -> readies drop at outstanding=32. One wr_done -> outstanding=31, and ready returns the next cycle.
- Same cycle: accept + wr_done + rd_done with outstanding=4 -> outstanding=3.
- rd_done with outstanding=0 -> outstanding stays 0 and fir_credit_underflow=1. It persists until rst, and rst clears all outputs.
